// File: rtl/ser_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : ser_stream_tx
// Purpose  : WIDTH-bit valid/ready word in, one serial bit per clk out, with
//            back-to-back words contiguous. Define SER_PARITY_EN for a trailing
//            even-parity cycle after every word.
// Revision : 1.0
// ============================================================================
module ser_stream_tx #(
    parameter int   WIDTH      = 16,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dataout,
    output logic             frame,
    output logic             next,
    output logic             busy
);
    localparam int                 C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [C_CNT_W-1:0] r_count, w_count_nxt;
    logic               r_next;
    logic               w_cur_bit;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_ready;
    logic               w_accept;
    logic               w_dout;
    logic               w_frame;
`ifdef SER_PARITY_EN
    logic               r_parity, w_parity_nxt;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_cur_bit = r_shift[WIDTH-1];
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_cur_bit = r_shift[0];
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_count_nxt  = r_count;
        w_ready      = 1'b0;
        w_dout       = IDLE_LEVEL;
        w_frame      = 1'b0;
`ifdef SER_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_SHIFT: begin
                w_dout      = w_cur_bit;
                w_frame     = 1'b1;
                w_shift_nxt = w_shifted;
                if (r_count == C_LAST) begin
                    w_count_nxt = '0;
`ifdef SER_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    // Last data bit: a new word may be taken with no gap.
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_count_nxt = r_count + C_CNT_W'(1);
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                w_dout      = r_parity;
                w_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_accept = in_valid && w_ready;
        if (w_accept) begin
            w_state_nxt  = ST_SHIFT;
            w_shift_nxt  = datain;
            w_count_nxt  = '0;
`ifdef SER_PARITY_EN
            w_parity_nxt = ^datain;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_count  <= '0;
            r_next   <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_count  <= w_count_nxt;
            r_next   <= w_accept;
`ifdef SER_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    // Outputs are forced quiet while reset is held, not only after its edge.
    assign in_ready = rst & w_ready;
    assign dataout  = rst ? w_dout : IDLE_LEVEL;
    assign frame    = rst & w_frame;
    assign next     = rst & r_next;
    assign busy     = rst & (r_state != ST_IDLE);

endmodule
`default_nettype wire
